// File: rtl/trace_port_tx.sv
// Parallel trace port transmitter: serialises TPIU frames and syncs LSB-first onto a 1/2/4-bit DDR pin pair.
// Optional frame/sync statistics counters are built when TRACE_TX_STATS_EN is defined.
module trace_port_tx #(
    parameter int MAXBUSWIDTH   = 4,
    parameter int STARTUP_SYNCS = 4,
    parameter int SYNC_INTERVAL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             Width,
    input  logic [127:0]           Frame,
    input  logic                   FrameValid,
    output logic                   FrameReady,
    output logic [MAXBUSWIDTH-1:0] TraceDa,
    output logic [MAXBUSWIDTH-1:0] TraceDb,
    output logic                   Busy,
    output logic [31:0]            TotalFrames,
    output logic [15:0]            SyncsSent
);

    localparam logic [0:0] ST_STARTUP = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    localparam logic [1:0]  MAX_SHIFT    = (MAXBUSWIDTH >= 4) ? 2'd2 : (MAXBUSWIDTH >= 2) ? 2'd1 : 2'd0;
    localparam logic [7:0]  STARTUP_LAST = 8'(STARTUP_SYNCS - 1);
    localparam logic [15:0] SYNC_INT     = 16'(SYNC_INTERVAL);
    localparam logic [31:0] FULL_SYNC    = 32'h7FFF_FFFF;
    localparam logic [15:0] HALF_SYNC    = 16'h7FFF;

    logic [0:0]   state;
    logic [7:0]   startup_cnt;
    logic [15:0]  frame_cnt;
    logic [127:0] sh;
    logic [6:0]   beats_left;
    logic [1:0]   cur_ws;
    logic         is_frame;

    logic [1:0]   req_ws;
    logic [1:0]   next_ws;
    logic         last_beat;
    logic         sync_due;
    logic         load_sync;
    logic         load_frame;

    // Width is log2-encoded as a shift amount: 0 -> 1 pin, 1 -> 2 pins, 2 -> 4 pins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_ws = 2'd2;
        case (Width)
            2'd0:    req_ws = 2'd0;
            2'd1:    req_ws = 2'd1;
            default: req_ws = 2'd2;
        endcase
        next_ws = (req_ws > MAX_SHIFT) ? MAX_SHIFT : req_ws;
    end

    // beats_left is 0 only straight out of reset, which makes the first edge a unit boundary.
    assign last_beat  = (beats_left <= 7'd1);
    assign sync_due   = (SYNC_INTERVAL != 0) && (frame_cnt == SYNC_INT);
    assign FrameReady = (state == ST_RUN) && last_beat && !sync_due;
    assign load_sync  = last_beat && ((state == ST_STARTUP) || sync_due);
    assign load_frame = FrameValid && FrameReady;
    assign Busy       = is_frame;

    always_comb begin
        TraceDa = '0;
        TraceDb = '0;
        for (int i = 0; i < MAXBUSWIDTH; i++) begin
            if (i < (1 << cur_ws)) begin
                TraceDa[i] = sh[i];
                TraceDb[i] = sh[i + (1 << cur_ws)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sh         <= '0;
            beats_left <= '0;
            cur_ws     <= '0;
            is_frame   <= 1'b0;
        end else if (last_beat) begin
            cur_ws   <= next_ws;
            is_frame <= load_frame;
            if (load_sync) begin
                sh         <= {96'd0, FULL_SYNC};
                beats_left <= 7'd16 >> next_ws;
            end else if (load_frame) begin
                sh         <= Frame;
                beats_left <= 7'd64 >> next_ws;
            end else begin
                sh         <= {112'd0, HALF_SYNC};
                beats_left <= 7'd8 >> next_ws;
            end
        end else begin
            beats_left <= beats_left - 7'd1;
            case (cur_ws)
                2'd0:    sh <= sh >> 2;
                2'd1:    sh <= sh >> 4;
                default: sh <= sh >> 8;
            endcase
        end
    end

    // RUN is entered as the last startup sync loads, so FrameReady can rise in its final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_STARTUP;
            startup_cnt <= '0;
            frame_cnt   <= '0;
        end else begin
            if (load_sync && (state == ST_STARTUP)) begin
                startup_cnt <= startup_cnt + 8'd1;
                if (startup_cnt == STARTUP_LAST) begin
                    state <= ST_RUN;
                end
            end
            if (load_sync) begin
                frame_cnt <= '0;
            end else if (load_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef TRACE_TX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TotalFrames <= '0;
            SyncsSent   <= '0;
        end else begin
            if (load_frame) TotalFrames <= TotalFrames + 32'd1;
            if (load_sync)  SyncsSent   <= SyncsSent + 16'd1;
        end
    end
`else
    assign TotalFrames = '0;
    assign SyncsSent   = '0;
`endif

endmodule

// File: tb/tb_trace_port_tx.sv
// Scoreboarded bench for trace_port_tx: accepted frames are queued, a pin monitor reassembles and compares them.
module tb_trace_port_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   width;
    logic [127:0] frame;
    logic         frame_valid;
    logic         frame_ready;
    logic [3:0]   trace_da;
    logic [3:0]   trace_db;
    logic         busy;
    logic [31:0]  total_frames;
    logic [15:0]  syncs_sent;

    int checks = 0;
    int errors = 0;
    int frames_checked = 0;

    typedef struct {
        logic [127:0] data;
        int           ws;
    } exp_t;

    exp_t sb_q[$];

    trace_port_tx #(
        .MAXBUSWIDTH  (4),
        .STARTUP_SYNCS(4),
        .SYNC_INTERVAL(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Width      (width),
        .Frame      (frame),
        .FrameValid (frame_valid),
        .FrameReady (frame_ready),
        .TraceDa    (trace_da),
        .TraceDb    (trace_db),
        .Busy       (busy),
        .TotalFrames(total_frames),
        .SyncsSent  (syncs_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_ready && waited < 200);
        if (!frame_ready) check("ready_timeout", {127'd0, frame_ready}, 128'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("idle_timeout", {127'd0, busy}, 128'd0);
    endtask

    task automatic push_exp(input logic [127:0] data, input int ws);
        exp_t e;
        e.data = data;
        e.ws   = ws;
        sb_q.push_back(e);
    endtask

    // Entered at a negedge with rst just released and Width=2, FrameValid=0.
    task automatic check_startup();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("startup_beat", {118'd0, trace_da, trace_db, frame_ready, busy},
                  {118'd0, 4'hF, (k % 4 == 3) ? 4'h7 : 4'hF, (k == 15), 1'b0});
        end
        @(negedge clk);
        check("halfsync_beat0", {118'd0, trace_da, trace_db, frame_ready, busy}, {118'd0, 4'hF, 4'hF, 2'b00});
        @(negedge clk);
        check("halfsync_beat1", {118'd0, trace_da, trace_db, frame_ready, busy}, {118'd0, 4'hF, 4'h7, 2'b10});
    endtask

    // Monitor: reassembles every frame shown while Busy is high and compares it with the queue head.
    initial begin
        exp_t         cur;
        logic [127:0] acc;
        bit           active = 0;
        bit           unused_hit;
        int           k;
        int           w;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else begin
                if (!active && busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", 128'(sb_q.size()), 128'd1);
                    end else begin
                        cur        = sb_q.pop_front();
                        active     = 1;
                        acc        = '0;
                        k          = 0;
                        unused_hit = 0;
                    end
                end else if (active && !busy) begin
                    check("busy_dropped", {127'd0, busy}, 128'd1);
                    active = 0;
                end
                if (active) begin
                    w = 1 << cur.ws;
                    for (int i = 0; i < 4; i++) begin
                        if (i < w) begin
                            acc[k*2*w + i]     = trace_da[i];
                            acc[k*2*w + w + i] = trace_db[i];
                        end else if (trace_da[i] || trace_db[i]) begin
                            unused_hit = 1;
                        end
                    end
                    k++;
                    if (k == (64 >> cur.ws)) begin
                        check("frame_data", acc, cur.data);
                        check("unused_pins", {127'd0, unused_hit}, 128'd0);
                        frames_checked++;
                        active = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] frames [9];
        logic [1:0]   w1_tbl [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
        logic [127:0] frame_w1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1EF;
        logic [127:0] frame_a  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        logic [127:0] frame_b  = 128'hB7C6D5E4_F3021324_35465768_798A9BAC;
        logic [127:0] frame_c  = 128'hC0FFEE00_11223344_55667788_99AABBCC;
        int waited;
        int extra;
        int n_busy;
        bit hi_pins;

        frames[0] = 128'h00000000_00000000_01234567_89ABCDEF;
        for (int i = 1; i < 9; i++) begin
            frames[i] = {32'(i) * 32'h0101_0101, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'h5A5A_0000 + 32'(i)};
        end

        // Reset values, then the startup sync run and the first halfsync.
        rst         = 1'b1;
        width       = 2'd2;
        frame       = '0;
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {117'd0, trace_da, trace_db, frame_ready, busy, 1'b0}, 128'd0);
        check("reset_stats", {80'd0, total_frames, syncs_sent}, 128'd0);
        rst = 1'b0;
        check_startup();

        // Nine back-to-back frames at 4 bits: a forced full sync must separate frames 8 and 9.
        @(posedge clk); #1;
        extra = 0;
        for (int i = 0; i < 9; i++) begin
            frame       = frames[i];
            frame_valid = 1'b1;
            wait_ready(waited);
            if (i > 0) check("frame_gap", 128'(waited + extra), (i == 8) ? 128'd20 : 128'd16);
            push_exp(frames[i], 2);
            @(posedge clk); #1;
            extra = 0;
            if (i == 0) begin
                @(negedge clk);
                check("first_beat", {119'd0, trace_da, trace_db, busy}, {119'd0, 4'hF, 4'hE, 1'b1});
                @(negedge clk);
                check("second_beat", {119'd0, trace_da, trace_db, busy}, {119'd0, 4'hD, 4'hC, 1'b1});
                extra = 2;
            end
        end
        frame_valid = 1'b0;
`ifdef TRACE_TX_STATS_EN
        check("stats_after_9", {80'd0, total_frames, syncs_sent}, {80'd0, 32'd9, 16'd5});
`else
        check("stats_tied_off", {80'd0, total_frames, syncs_sent}, 128'd0);
`endif
        wait_idle(100);

        // One-bit width: 64 beats, upper pins held at 0.
        width       = 2'd0;
        frame       = frame_w1;
        frame_valid = 1'b1;
        wait_ready(waited);
        push_exp(frame_w1, 0);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        n_busy  = 0;
        hi_pins = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (k < 4) check("w1_beat", {126'd0, trace_da[0], trace_db[0]}, {126'd0, w1_tbl[k]});
            if (trace_da[3:1] != 3'd0 || trace_db[3:1] != 3'd0) hi_pins = 1;
            n_busy++;
        end
        check("w1_busy_cycles", 128'(n_busy), 128'd64);
        check("w1_upper_pins", {127'd0, hi_pins}, 128'd0);

        // Width change mid-frame: A keeps the 4-bit rate, B goes out 1 bit wide.
        width       = 2'd2;
        frame       = frame_a;
        frame_valid = 1'b1;
        wait_ready(waited);
        push_exp(frame_a, 2);
        @(posedge clk); #1;
        frame = frame_b;
        repeat (5) @(negedge clk);
        width = 2'd0;
        wait_ready(waited);
        check("midframe_width_gap", 128'(waited + 5), 128'd16);
        push_exp(frame_b, 0);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        wait_idle(100);

        // Reset in the middle of a frame.
        width       = 2'd2;
        frame       = frame_c;
        frame_valid = 1'b1;
        wait_ready(waited);
        push_exp(frame_c, 2);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midframe_reset", {118'd0, trace_da, trace_db, frame_ready, busy}, 128'd0);
        repeat (2) @(negedge clk);
        check("reset_stats_cleared", {80'd0, total_frames, syncs_sent}, 128'd0);
        rst = 1'b0;
        check_startup();

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        check("frames_checked", 128'(frames_checked), 128'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_port_tx.md
Name: trace_port_tx

Overview:
- Parallel trace port transmitter: the transmit end of the DDR trace-pin interface that traceIF receives.
- Takes 128-bit TPIU frames from an upstream source and serialises them LSB-first onto a 1/2/4-bit DDR bus.
- Inserts TPIU full syncs (0x7FFFFFFF) at startup and periodically, and halfword syncs (0x7FFF) when idle.
- Used for loopback self-test and for bench stimulus of the receive chain; drives external ODDR primitives clocked by clk.

Parameters:
- MAXBUSWIDTH, 4, physical pin count per edge; supported values 1, 2, 4.
- STARTUP_SYNCS, 4, number of full syncs sent after reset before any frame.
- SYNC_INTERVAL, 8, frames between forced full syncs; 0 disables periodic sync.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- Width  input  2  bus width: 0 = 1 bit, 1 = 2 bits, 2 or 3 = 4 bits (clamped to MAXBUSWIDTH).
- Frame  input  128  frame to send; byte 0 in bits [7:0].
- FrameValid  input  1  Frame holds valid data.
- FrameReady  output  1  block accepts Frame at this edge when FrameValid is also high.
- TraceDa  output  MAXBUSWIDTH  first-edge data to ODDR.
- TraceDb  output  MAXBUSWIDTH  second-edge data to ODDR.
- Busy  output  1  a data frame, not a sync, is on the pins.
- TotalFrames  output  32  frames sent (optional feature).
- SyncsSent  output  16  full syncs sent (optional feature).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: TraceDa=0, TraceDb=0, FrameReady=0, Busy=0, all counters 0, state STARTUP.
- Units: full sync = 32 bits, halfword sync = 16 bits, frame = 128 bits.
- Each unit is shifted LSB-first, 2w bits per clk (w = effective width).
  - TraceDa takes the lower w bits; TraceDb takes the next w bits.
  - Unused pins (index ≥ w) are driven 0.
- Beats per unit = bits/(2w):
  - w=4: frame 16, sync 4, halfsync 2.
  - w=2: frame 32, sync 8, halfsync 4.
  - w=1: frame 64, sync 16, halfsync 8.
- Unit boundary: the edge that completes the last beat of the current unit.
  - The next unit is loaded on that edge, and its first beat is on the pins after the same edge. There are no gap cycles.
  - Width is sampled only at a boundary; a mid-unit Width change takes effect at the next unit.
- States:
  - STARTUP: emits STARTUP_SYNCS full syncs back to back, then enters RUN. FrameReady=0 throughout.
  - RUN: at each boundary, choose the next unit in priority order:
    - (a) full sync if SYNC_INTERVAL≠0 and the frame count since the last sync = SYNC_INTERVAL; the count resets to 0;
    - (b) Frame if FrameValid && FrameReady; the count increments;
    - (c) halfword sync.
- FrameReady = RUN && last beat of current unit && !syncDue; combinational from registered state.
  - FrameValid may rise or fall at any time; a transfer occurs only on an edge where both are high.
  - Frame is captured on that edge. Upstream may change Frame afterwards.
- Busy is high exactly on the cycles whose pins carry frame beats.
- Reset mid-unit: the unit is abandoned, outputs go to reset values immediately, and STARTUP restarts on release.
- Counters wrap modulo their width.

Optional Feature:
- Macro: TRACE_TX_STATS_EN.
- Defined:
  - TotalFrames increments at each frame load.
  - SyncsSent increments at each full-sync load, startup syncs included.
  - Both are cleared by rst.
- Undefined: TotalFrames and SyncsSent are tied to 0 and no counter logic is built.

Test Plan:
- Reset release, Width=2, FrameValid=0 → 16 cycles of startup syncs, then halfsyncs. Every 4-cycle sync ends with Da=F Db=7; FrameReady first high in the last beat of the 4th sync.
- Width=2, Frame=0x…0123456789ABCDEF (low bytes), held valid → first beat Da=F Db=E, second Da=D Db=C. Busy is high for exactly 16 cycles.
- Width=0, byte0=0xEF → first beats (Da[0],Db[0]) = (1,1),(1,1),(0,1),(1,1). Pins [3:1] stay 0; frame lasts 64 cycles.
- SYNC_INTERVAL=8, FrameValid held high, Width=2 → after 8 frames one full sync (4 cycles, FrameReady=0), then frame 9; with TRACE_TX_STATS_EN, SyncsSent=5 and TotalFrames=9.
- Width changed 2→0 mid-frame → current frame finishes at 4-bit rate; the next unit uses 1-bit beats.
- rst asserted mid-frame → pins go to 0 immediately, FrameReady goes to 0, and STARTUP syncs restart on release.
